int_tx_dec: RTL and testbench
=============================

# int_tx_dec

Parametrised binary-to-ASCII-decimal transmit formatter for the UART TX path. It accepts an NBIT-wide ALU result, optionally interpreted as two's complement. It converts the value to decimal with a fixed-latency double-dabble engine and writes the digit string to the TX FIFO: optional '-', most significant digit first, leading zeros suppressed, optional terminator character. FIFO backpressure is honoured on every character, so none is lost or duplicated.

## Interface
- NBIT, 8, input data width (>= 4)
- SIGNED, 0, 1 = DATO is two's complement and negative values are emitted with '-'
- TERM_EN, 1, 1 = append TERM_CHAR after the last digit
- TERM_CHAR, 8'h0A, terminator byte
- Derived localparam ND = ((NBIT*1233)>>12)+1, the number of BCD digits.

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- enviar  in  1  start request; sampled only in IDLE
- DATO  in  NBIT  value to format; sampled on the accepting edge only
- fifo_full  in  1  TX FIFO full; no write while high
- WR_FIFO  out  1  FIFO write strobe; the FIFO captures data_fifo on the edge where WR_FIFO=1
- data_fifo  out  8  ASCII byte being written
- busy  out  1  high from the accepting edge until the string is complete
- done  out  1  one-cycle pulse after the final character is written

## Operation
States:
- **IDLE**
  - busy=0.
  - On enviar=1, latch the magnitude: -DATO mod 2^NBIT if SIGNED and DATO[NBIT-1]=1, else DATO.
  - Set neg accordingly, clear the ND-digit BCD register, load bit counter = NBIT, go to CONV.
- **CONV**
  - Each cycle: add 3 to every BCD digit >= 5, then shift {BCD, magnitude} left by 1.
  - After NBIT cycles, set digit index idx = position of the most significant nonzero digit (0 if all zero).
  - Next state is SIGN if neg, else EMIT.
- **SIGN**
  - data_fifo=8'h2D; WR_FIFO = !fifo_full.
  - On a write, go to EMIT; otherwise hold.
- **EMIT**
  - data_fifo = 8'h30 + BCD[idx]; WR_FIFO = !fifo_full.
  - On a write with idx>0: idx decrements.
  - On a write with idx=0: go to TERM if TERM_EN, else IDLE with done.
- **TERM**
  - data_fifo = TERM_CHAR; WR_FIFO = !fifo_full.
  - On a write, go to IDLE with done.

Rules:
- WR_FIFO and data_fifo are combinational from state, idx and fifo_full. WR_FIFO=0 in IDLE and CONV.
- Only leading zeros are suppressed; interior and trailing zeros are emitted. The value 0 emits the single character '0'.
- Most negative input with SIGNED=1 is handled: 8'h80 has magnitude 128.
- enviar while busy=1 is ignored; no queuing.
- DATO changes after acceptance have no effect.
- fifo_full high only stalls the current character. The state, idx and data_fifo value are held, and emission resumes on the first cycle fifo_full=0.

## Timing
- Reset values: state IDLE, WR_FIFO=0, busy=0, done=0, data_fifo=8'h00, idx=0, BCD=0, neg=0.
- RESET mid-operation aborts on the next edge: WR_FIFO=0 immediately after that edge and no further characters are written. Characters already in the FIFO remain.
- Let E0 be the edge accepting enviar. CONV spans the NBIT cycles after E0. The first WR_FIFO=1 is in cycle NBIT+1 after E0, provided fifo_full=0.
- With no backpressure, K characters are written on K consecutive cycles. done=1 in the cycle after the last write, and busy=0 in that same cycle.
- Each cycle with fifo_full=1 in SIGN, EMIT or TERM adds exactly one cycle of latency.
- enviar=1 while done=1 is in IDLE and is accepted, giving back-to-back strings with a one-cycle gap.
- Throughput: at most one character per cycle.

## Test plan
- **Zero and maximum** (NBIT=8, SIGNED=0, TERM_EN=1): DATO=0 writes 8'h30, 8'h0A. DATO=255 writes 8'h32, 8'h35, 8'h35, 8'h0A, with the first WR_FIFO 9 cycles after E0 and done 1 cycle after the LF.
- **Signed**
  - SIGNED=1, DATO=8'h80 writes "-128\n".
  - DATO=8'hFF writes "-1\n".
  - DATO=8'h7F writes "127\n".
- **Backpressure**: DATO=200 with fifo_full held high for 5 cycles while the '0' is pending. The FIFO receives exactly "200\n", data_fifo is stable during the stall, and done is delayed by 5 cycles.
- **Wide and interior zeros** (NBIT=16, TERM_EN=0): DATO=1000 writes "1000". DATO=65535 writes "65535". No terminator is written in either case.
- **Control edges**
  - enviar pulsed during CONV and EMIT produces no extra string.
  - RESET asserted after 2 of 4 characters: no further writes, busy=0 and done=0 after the edge.
  - enviar asserted in the done cycle starts a new string.

Source files
------------

// File: rtl/int_tx_dec.sv
// Binary to ASCII decimal formatter for the UART TX path: double-dabble conversion,
// then sign, digits (leading zeros suppressed) and optional terminator into the TX FIFO.
module int_tx_dec #(
  parameter int          NBIT      = 8,
  parameter int          SIGNED    = 0,
  parameter int          TERM_EN   = 1,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            enviar,
  input  logic [NBIT-1:0] DATO,
  input  logic            fifo_full,
  output logic            WR_FIFO,
  output logic [7:0]      data_fifo,
  output logic            busy,
  output logic            done
);

  localparam int ND = ((NBIT * 1233) >> 12) + 1;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int CW = $clog2(NBIT + 1);

  // Handshake: a character moves into the FIFO on every rising edge where
  // WR_FIFO=1; WR_FIFO is never raised while fifo_full=1, and nothing advances
  // in SIGN/EMIT/TERM until that write happens.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_SIGN = 3'd2,
    S_EMIT = 3'd3,
    S_TERM = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NBIT-1:0]       mag_q, mag_d;
  logic [ND-1:0][3:0]    bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  neg_q, neg_d;
  logic                  done_q, done_d;

  logic [ND-1:0][3:0]    adj;
  logic [4*ND-1:0]       adj_flat;
  logic                  neg_in;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // Double-dabble correction step applied before each shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
    end
    adj_flat = adj;
  end

  assign neg_in = (SIGNED != 0) && DATO[NBIT-1];

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    WR_FIFO   = 1'b0;
    data_fifo = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (enviar) begin
          mag_d   = neg_in ? -DATO : DATO;
          neg_d   = neg_in;
          bcd_d   = '0;
          cnt_d   = CW'(NBIT);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = {adj_flat[4*ND-2:0], mag_q[NBIT-1]};
        mag_d = {mag_q[NBIT-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          idx_d = '0;
          for (int i = 0; i < ND; i++) begin
            if (bcd_d[i] != 4'd0) idx_d = IW'(i);
          end
          state_d = neg_q ? S_SIGN : S_EMIT;
        end
      end
      S_SIGN: begin
        data_fifo = 8'h2D;
        WR_FIFO   = !fifo_full;
        if (!fifo_full) state_d = S_EMIT;
      end
      S_EMIT: begin
        data_fifo = 8'h30 + {4'h0, bcd_q[idx_q]};
        WR_FIFO   = !fifo_full;
        if (!fifo_full) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (TERM_EN != 0) begin
            state_d = S_TERM;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_TERM: begin
        data_fifo = TERM_CHAR;
        WR_FIFO   = !fifo_full;
        if (!fifo_full) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_int_tx_dec.sv
// Bench for int_tx_dec: three configurations (8-bit unsigned, 8-bit signed,
// 16-bit no terminator) driven with directed and random strings.
module tb_int_tx_dec;

  logic        clk;
  logic        reset;
  logic        en0, en1, en2;
  logic        ff0, ff1, ff2;
  logic [7:0]  dato0, dato1;
  logic [15:0] dato2;
  logic        wr0, wr1, wr2;
  logic [7:0]  df0, df1, df2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  int_tx_dec #(.NBIT(8), .SIGNED(0), .TERM_EN(1), .TERM_CHAR(8'h0A)) u_u8 (
    .CLK(clk), .RESET(reset), .enviar(en0), .DATO(dato0), .fifo_full(ff0),
    .WR_FIFO(wr0), .data_fifo(df0), .busy(busy0), .done(done0));

  int_tx_dec #(.NBIT(8), .SIGNED(1), .TERM_EN(1), .TERM_CHAR(8'h0A)) u_s8 (
    .CLK(clk), .RESET(reset), .enviar(en1), .DATO(dato1), .fifo_full(ff1),
    .WR_FIFO(wr1), .data_fifo(df1), .busy(busy1), .done(done1));

  int_tx_dec #(.NBIT(16), .SIGNED(0), .TERM_EN(0), .TERM_CHAR(8'h0A)) u_u16 (
    .CLK(clk), .RESET(reset), .enviar(en2), .DATO(dato2), .fifo_full(ff2),
    .WR_FIFO(wr2), .data_fifo(df2), .busy(busy2), .done(done2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // per-instance accessors
  function automatic int nbit_of(input int k);
    return (k == 2) ? 16 : 8;
  endfunction
  function automatic logic wr_of(input int k);
    return (k == 0) ? wr0 : (k == 1) ? wr1 : wr2;
  endfunction
  function automatic logic busy_of(input int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction
  function automatic logic done_of(input int k);
    return (k == 0) ? done0 : (k == 1) ? done1 : done2;
  endfunction
  function automatic logic [7:0] df_of(input int k);
    return (k == 0) ? df0 : (k == 1) ? df1 : df2;
  endfunction

  task automatic set_en(input int k, input logic b);
    if (k == 0) en0 = b; else if (k == 1) en1 = b; else en2 = b;
  endtask
  task automatic set_ff(input int k, input logic b);
    if (k == 0) ff0 = b; else if (k == 1) ff1 = b; else ff2 = b;
  endtask
  task automatic set_dato(input int k, input logic [15:0] v);
    if (k == 0) dato0 = v[7:0]; else if (k == 1) dato1 = v[7:0]; else dato2 = v;
  endtask

  // reference model: decimal string by plain arithmetic
  task automatic build_exp(input int k, input logic [15:0] v);
    int n, val, lim;
    bit sgn, term, neg;
    int digs[$];
    n    = nbit_of(k);
    sgn  = (k == 1);
    term = (k != 2);
    lim  = 1 << n;
    val  = int'(v) % lim;
    neg  = 1'b0;
    if (sgn && val >= lim / 2) begin
      neg = 1'b1;
      val = lim - val;
    end
    do begin
      digs.push_front(val % 10);
      val = val / 10;
    end while (val > 0);
    if (neg) exp_q.push_back(8'h2D);
    foreach (digs[i]) exp_q.push_back(8'(8'h30 + digs[i]));
    if (term) exp_q.push_back(8'h0A);
  endtask

  // one string: drives enviar, optional stall/pulse/reset, checks chars and timing
  task automatic send(input int k, input logic [15:0] v, input int stall_len,
                      input int stall_at, input bit from_done, input bit pulse_en,
                      input int rst_after);
    int nb, kexp, nwr, first_c, done_c, scnt, cur;
    bit busy_bad, fin, was_reset;
    nb = nbit_of(k);
    exp_q.delete();
    build_exp(k, v);
    kexp = exp_q.size();
    if (!from_done) begin
      @(posedge clk); #1;
    end
    set_en(k, 1'b1);
    set_dato(k, v);
    @(posedge clk); #1;
    set_en(k, 1'b0);
    set_dato(k, 16'($urandom));
    nwr = 0; first_c = 0; done_c = 0; scnt = 0;
    busy_bad = 1'b0; fin = 1'b0; was_reset = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      set_en(k, pulse_en && (c == 3 || c == nb + 2));
      cur = (c >= nb + 1 && nwr == stall_at && scnt < stall_len) ? 1 : 0;
      if (cur == 1) scnt++;
      set_ff(k, cur == 1);
      @(negedge clk);
      if (done_of(k)) begin
        done_c = c;
        fin    = 1'b1;
        check_val("busy_in_done", busy_of(k), 1'b0);
      end else begin
        if (!busy_of(k)) busy_bad = 1'b1;
        if (cur == 1 && exp_q.size() > 0) begin
          check_val("stall_no_wr", wr_of(k), 1'b0);
          check_val("stall_hold", df_of(k), exp_q[0]);
        end
        if (wr_of(k)) begin
          if (first_c == 0) first_c = c;
          if (exp_q.size() == 0) check_val("extra_char", 1, 0);
          else check_val("char", df_of(k), exp_q.pop_front());
          nwr++;
          if (rst_after > 0 && nwr == rst_after) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_val("rst_wr", wr_of(k), 1'b0);
            check_val("rst_busy", busy_of(k), 1'b0);
            check_val("rst_done", done_of(k), 1'b0);
            check_val("rst_data", df_of(k), 8'h00);
            fin = 1'b1;
            was_reset = 1'b1;
          end
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    set_ff(k, 1'b0);
    set_en(k, 1'b0);
    if (!fin) check_val("timeout", 1, 0);
    else if (was_reset) check_val("rst_nchars", nwr, rst_after);
    else begin
      check_val("nchars", nwr, kexp);
      check_val("first_wr_cycle", first_c, nb + 1 + ((stall_at == 0) ? stall_len : 0));
      check_val("done_cycle", done_c, nb + kexp + 1 + ((stall_at < kexp) ? stall_len : 0));
      check_val("busy_during", busy_bad, 1'b0);
    end
  endtask

  task automatic quiet(input int k, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_of(k) || busy_of(k)) bad = 1'b1;
    end
    check_val("quiet", bad, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    en0 = 0; en1 = 0; en2 = 0;
    ff0 = 0; ff1 = 0; ff2 = 0;
    dato0 = 0; dato1 = 0; dato2 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val("reset_wr", wr_of(k), 1'b0);
      check_val("reset_busy", busy_of(k), 1'b0);
      check_val("reset_done", done_of(k), 1'b0);
      check_val("reset_data", df_of(k), 8'h00);
    end

    // unsigned 8-bit: zero, max, backpressure on the '0'
    send(0, 16'd0, 0, 0, 0, 0, 0);
    send(0, 16'd255, 0, 0, 0, 0, 0);
    send(0, 16'd200, 5, 1, 0, 0, 0);
    // signed 8-bit
    send(1, 16'h80, 0, 0, 0, 0, 0);
    send(1, 16'hFF, 0, 0, 0, 0, 0);
    send(1, 16'h7F, 0, 0, 0, 0, 0);
    send(1, 16'h00, 2, 0, 0, 0, 0);
    // 16-bit, no terminator
    send(2, 16'd1000, 0, 0, 0, 0, 0);
    send(2, 16'd65535, 0, 0, 0, 0, 0);
    send(2, 16'd0, 0, 0, 0, 0, 0);
    // enviar pulsed during CONV and EMIT
    send(0, 16'd123, 0, 0, 0, 1, 0);
    quiet(0, 12);
    // back-to-back from the done cycle
    send(1, 16'hFB, 0, 0, 0, 0, 0);
    send(1, 16'd42, 0, 0, 1, 0, 0);
    quiet(1, 5);
    // reset after 2 of 4 characters
    send(0, 16'd255, 0, 0, 0, 0, 2);
    quiet(0, 12);

    for (int i = 0; i < 30; i++) begin
      send($urandom_range(0, 2), 16'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 5), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
